// File: rtl/aux_input_debouncer_if.sv
// Board-input bundle for aux_input_debouncer: raw pins in, clean levels and strobes out.
// The master side drives the raw pins; the debouncer is the slave.
interface aux_input_debouncer_if #(
  parameter int unsigned SwtBit = 16
);
  logic              resume_raw;
  logic [SwtBit-1:0] swt_raw;
  logic              resume;
  logic              resume_pulse;
  logic [SwtBit-1:0] swt;
  logic              swt_changed;

  modport master (
    output resume_raw,
    output swt_raw,
    input  resume,
    input  resume_pulse,
    input  swt,
    input  swt_changed
  );

  modport slave (
    input  resume_raw,
    input  swt_raw,
    output resume,
    output resume_pulse,
    output swt,
    output swt_changed
  );
endinterface

// File: rtl/aux_input_debouncer.sv
// Two-FF synchroniser plus per-channel debounce counter for the resume button and slide switches.
// Emits clean levels, a registered resume rising-edge pulse and a registered switch-change strobe.
module aux_input_debouncer #(
  parameter int unsigned SwtBit      = 16,
  parameter int unsigned DebounceCnt = 1000000,
  parameter int unsigned CntBit      = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  aux_input_debouncer_if.slave io
);

  // Channel SwtBit is the resume button; channels SwtBit-1..0 are the switches.
  localparam int unsigned ChBit = SwtBit + 1;
  localparam logic [CntBit-1:0] TermCnt = CntBit'(DebounceCnt - 1);

  logic [ChBit-1:0]  raw_vec;
  logic [ChBit-1:0]  sync1;
  logic [ChBit-1:0]  sync2;
  logic [ChBit-1:0]  acc;
  logic [ChBit-1:0]  acc_next;
  logic [CntBit-1:0] cnt      [ChBit];
  logic [CntBit-1:0] cnt_next [ChBit];
  logic              resume_pulse_q;
  logic              swt_changed_q;

  assign raw_vec = {io.resume_raw, io.swt_raw};

  // Any sample equal to the accepted level clears the count, so only an
  // unbroken run of DebounceCnt differing samples flips the accepted level.
  always_comb begin
    acc_next = acc;
    for (int unsigned ch = 0; ch < ChBit; ch++) begin
      cnt_next[ch] = '0;
      if (sync2[ch] != acc[ch]) begin
        if (cnt[ch] == TermCnt) begin
          acc_next[ch] = sync2[ch];
        end else begin
          cnt_next[ch] = cnt[ch] + CntBit'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1          <= '0;
      sync2          <= '0;
      acc            <= '0;
      resume_pulse_q <= 1'b0;
      swt_changed_q  <= 1'b0;
      for (int unsigned ch = 0; ch < ChBit; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      sync1          <= raw_vec;
      sync2          <= sync1;
      acc            <= acc_next;
      resume_pulse_q <= acc_next[SwtBit] & ~acc[SwtBit];
      swt_changed_q  <= |(acc_next[SwtBit-1:0] ^ acc[SwtBit-1:0]);
      for (int unsigned ch = 0; ch < ChBit; ch++) begin
        cnt[ch] <= cnt_next[ch];
      end
    end
  end

  assign io.resume       = acc[SwtBit];
  assign io.swt          = acc[SwtBit-1:0];
  assign io.resume_pulse = resume_pulse_q;
  assign io.swt_changed  = swt_changed_q;

endmodule

// File: tb/tb_aux_input_debouncer.sv
// Directed bench for aux_input_debouncer with DebounceCnt=4, CntBit=3, SwtBit=16.
// Cycle k means the sample taken 1 time unit after the k-th rising edge following a drive.
module tb_aux_input_debouncer;

  logic clk;
  logic rst_n;
  int unsigned passed;
  int unsigned total;

  aux_input_debouncer_if #(.SwtBit(16)) io ();

  aux_input_debouncer #(
    .SwtBit(16),
    .DebounceCnt(4),
    .CntBit(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic res, input logic pls,
                         input logic [15:0] sw, input logic chg);
    chk({tag, ".resume"}, {31'd0, io.resume}, {31'd0, res});
    chk({tag, ".resume_pulse"}, {31'd0, io.resume_pulse}, {31'd0, pls});
    chk({tag, ".swt"}, {16'd0, io.swt}, {16'd0, sw});
    chk({tag, ".swt_changed"}, {31'd0, io.swt_changed}, {31'd0, chg});
  endtask

  initial begin
    passed = 0;
    total  = 0;

    // 1: inputs high through reset, accepted 6 cycles after release
    rst_n         = 1'b0;
    io.resume_raw = 1'b1;
    io.swt_raw    = 16'hFFFF;
    repeat (3) tick();
    chk_all("rst_hold", 1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all("rst_release", k >= 6, k == 6, (k >= 6) ? 16'hFFFF : 16'h0000, k == 6);
    end

    // return to all-zero
    io.resume_raw = 1'b0;
    io.swt_raw    = 16'h0000;
    repeat (10) tick();
    chk_all("idle", 1'b0, 1'b0, 16'h0000, 1'b0);

    // 2: clean press at 0, release at 20
    io.resume_raw = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      chk_all("press", (k >= 6) && (k < 26), k == 6, 16'h0000, 1'b0);
      if (k == 20) io.resume_raw = 1'b0;
    end

    // 3: bounce every 3 cycles for 30 cycles, then settle low
    io.resume_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk_all("bounce", 1'b0, 1'b0, 16'h0000, 1'b0);
      io.resume_raw = (k < 30) ? (((k / 3) % 2) == 0) : 1'b0;
    end

    // 4: staggered switch changes
    io.swt_raw = 16'h0003;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk_all("swt_stagger", 1'b0, 1'b0,
              (k >= 8) ? 16'h0103 : ((k >= 6) ? 16'h0003 : 16'h0000),
              (k == 6) || (k == 8));
      if (k == 2) io.swt_raw = 16'h0103;
    end

    // 5: bits 0 and 15 flip together
    io.swt_raw = 16'h8102;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all("swt_simul", 1'b0, 1'b0, (k >= 6) ? 16'h8102 : 16'h0103, k == 6);
    end

    // 6: reset during a press count
    io.resume_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_all("pre_rst", 1'b0, 1'b0, 16'h8102, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_all("in_rst", 1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk_all("post_rst", k >= 6, k == 6, (k >= 6) ? 16'h8102 : 16'h0000, k == 6);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
